// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the registered decode stage of the 16-bit ISA:
// instruction class / sub-op / function codes, ALU select constants, the packed
// datapath control struct and the combinational decode function.
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int CMD_W = 16;

   // Instruction class, COMMAND[15:14]
   typedef enum logic [1:0] {
      CLS_LD  = 2'b00,
      CLS_ST  = 2'b01,
      CLS_BR  = 2'b10,
      CLS_ALU = 2'b11
   } cls_e;

   // Legal sub-ops of the branch/immediate class, COMMAND[13:11]
   typedef enum logic [2:0] {
      SUB_LI  = 3'b000,
      SUB_B   = 3'b100,
      SUB_BCC = 3'b111
   } sub_e;

   // Function codes of the ALU class with special handling, COMMAND[7:4]
   localparam logic [3:0] FN_CMP = 4'b0101;
   localparam logic [3:0] FN_MOV = 4'b0110;
   localparam logic [3:0] FN_BAD = 4'b0111;
   localparam logic [3:0] FN_SRA = 4'b1011;  // last op that uses the address path
   localparam logic [3:0] FN_IN  = 4'b1100;  // last op that writes a register

   // Highest condition code BCC understands
   localparam logic [2:0] COND_MAX = 3'b011;

   // ALU select encodings
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SLR = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;
   localparam logic [3:0] ALU_SRA = 4'b1011;
   localparam logic [3:0] ALU_IDT = 4'b1100;
   localparam logic [3:0] ALU_NON = 4'b1111;

   // Datapath controls plus the source-read enables the hazard check needs
   typedef struct packed {
      logic [3:0] s_alu;
      logic       sign_ex;
      logic       ar_mux;
      logic       br_mux;
      logic       input_mux;
      logic       adr_mux;
      logic       write;
      logic       write_enable;
      logic       pc_load;
      logic       illegal;
      logic       rd_a;
      logic       rd_b;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{
      s_alu:        ALU_NON,
      sign_ex:      1'b0,
      ar_mux:       1'b0,
      br_mux:       1'b0,
      input_mux:    1'b0,
      adr_mux:      1'b0,
      write:        1'b0,
      write_enable: 1'b0,
      pc_load:      1'b0,
      illegal:      1'b0,
      rd_a:         1'b0,
      rd_b:         1'b0
   };

   function automatic ctrl_t decode(input logic [CMD_W-1:0] cmd);
      ctrl_t      c;
      cls_e       cls;
      sub_e       sub;
      logic [2:0] cnd;
      logic [3:0] fn;

      cls = cls_e'(cmd[15:14]);
      sub = sub_e'(cmd[13:11]);
      cnd = cmd[10:8];
      fn  = cmd[7:4];

      // NOTE: every field gets a value before the case so no path leaves one
      // unassigned; in combinational code that is what keeps latches out.
      c        = CTRL_RESET;
      c.br_mux = (cls != CLS_BR);

      case (cls)
         CLS_ALU: begin
            c.sign_ex   = 1'b1;
            c.write     = (fn <= FN_IN);
            c.ar_mux    = (fn <= FN_MOV);
            c.adr_mux   = (fn <= FN_SRA);
            c.input_mux = (fn == FN_IN);
            c.illegal   = (fn == FN_BAD);
            c.rd_a      = (fn != FN_IN);
            c.rd_b      = (fn != FN_IN) && (fn != FN_MOV);
            case (fn)
               FN_CMP:  c.s_alu = ALU_SUB;
               FN_MOV:  c.s_alu = ALU_IDT;
               default: c.s_alu = fn;
            endcase
         end
         CLS_LD: begin
            c.write = 1'b1;
            c.s_alu = ALU_ADD;
            c.rd_b  = 1'b1;
         end
         CLS_ST: begin
            c.write_enable = 1'b1;
            c.s_alu        = ALU_ADD;
            c.rd_a         = 1'b1;
            c.rd_b         = 1'b1;
         end
         CLS_BR: begin
            c.adr_mux = 1'b1;
            case (sub)
               SUB_LI: begin
                  c.write = 1'b1;
                  c.s_alu = ALU_IDT;
               end
               SUB_B: begin
                  c.pc_load = 1'b1;
                  c.s_alu   = ALU_ADD;
               end
               SUB_BCC: begin
                  c.pc_load = 1'b1;
                  c.s_alu   = ALU_ADD;
                  c.illegal = (cnd > COND_MAX);
               end
               default: c.illegal = 1'b1;
            endcase
         end
      endcase

      // Illegal words still flow to execute, but must not change any state
      if (c.illegal) begin
         c.write        = 1'b0;
         c.write_enable = 1'b0;
         c.pc_load      = 1'b0;
         c.s_alu        = ALU_NON;
      end
      return c;
   endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
// Per-register count of writes issued to execute but not yet retired. Flags a
// hazard when the held instruction reads a register with a pending write, or
// would push its destination past MAX_INFLIGHT outstanding writes.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rd_a_en, rd_a_addr   held instruction reads ra
//   rd_b_en, rd_b_addr   held instruction reads rb
//   wr_en, wr_addr       held instruction writes a register
//   issue                held instruction leaves the stage this cycle
//   wb_valid, wb_addr    a register write retires this cycle
//   hazard               held instruction must wait
// -----------------------------------------------------------------------------
module decode_scoreboard
   import decode_pkg::*;
#(
   parameter  int REG_COUNT    = 8,
   parameter  int MAX_INFLIGHT = 3,
   localparam int RA_W         = $clog2(REG_COUNT),
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_a_en,
   input  logic [RA_W-1:0] rd_a_addr,
   input  logic            rd_b_en,
   input  logic [RA_W-1:0] rd_b_addr,
   input  logic            wr_en,
   input  logic [RA_W-1:0] wr_addr,
   input  logic            issue,
   input  logic            wb_valid,
   input  logic [RA_W-1:0] wb_addr,
   output logic            hazard
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0]     cnt [REG_COUNT];
   logic [REG_COUNT-1:0] inc_vec;
   logic [REG_COUNT-1:0] dec_vec;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue && wr_en) inc_vec[wr_addr] = 1'b1;
      if (wb_valid)       dec_vec[wb_addr] = 1'b1;
   end

   assign hazard = (rd_a_en && (cnt[rd_a_addr] != '0))
                || (rd_b_en && (cnt[rd_b_addr] != '0))
                || (wr_en   && (cnt[wr_addr] == CNT_FULL));

   // NOTE: the counter array is small and its zero state is architecturally
   // meaningful (no writes pending), so every entry is reset explicitly; it
   // is not a data memory that can be left uninitialised.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < REG_COUNT; r++) begin
            // An issue and a retire on the same register cancel out. The hazard
            // check keeps an increment from ever wrapping past CNT_FULL.
            if (inc_vec[r] && !dec_vec[r])
               cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered decoder between fetch and execute. Accepts one command and its PC
// through a valid/ready handshake, decodes it into the datapath control set and
// holds the result in a single pipeline register. The held instruction is only
// offered to execute once no pending register write blocks it.
// The 16-bit ISA has 3-bit register fields, so REG_COUNT must stay 8.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   in_valid/in_ready        fetch handshake for COMMAND and in_pc
//   flush                    discard the held instruction
//   wb_valid, wb_addr        register write retiring in execute/writeback
//   out_valid/out_ready      execute handshake
//   out_pc                   PC of the held instruction
//   S_ALU ... PC_load        datapath controls
//   writeAddress, ra_addr,
//   rb_addr, cond            register fields and branch condition
//   illegal                  held instruction is an illegal encoding
//   stall                    held instruction is blocked by a hazard
// -----------------------------------------------------------------------------
module decode_stage
   import decode_pkg::*;
#(
   parameter  int PC_W         = 16,
   parameter  int REG_COUNT    = 8,
   parameter  int MAX_INFLIGHT = 3,
   localparam int RA_W         = $clog2(REG_COUNT)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     COMMAND,
   input  logic [PC_W-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_valid,
   input  logic [RA_W-1:0] wb_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [3:0]      S_ALU,
   output logic            signEx,
   output logic            AR_MUX,
   output logic            BR_MUX,
   output logic            INPUT_MUX,
   output logic            ADR_MUX,
   output logic            write,
   output logic            writeEnable,
   output logic            PC_load,
   output logic [RA_W-1:0] writeAddress,
   output logic [RA_W-1:0] ra_addr,
   output logic [RA_W-1:0] rb_addr,
   output logic [2:0]      cond,
   output logic            illegal,
   output logic            stall
);

   ctrl_t           dec_c;
   ctrl_t           held_c;
   logic            held_v;
   logic [PC_W-1:0] held_pc;
   logic [2:0]      held_ra;
   logic [2:0]      held_rb;   // rb, destination and branch condition share bits
   logic            hazard;
   logic            capture;
   logic            issue;

   assign dec_c = decode(COMMAND);

   assign out_valid = held_v && !hazard;
   assign stall     = held_v && hazard;
   assign issue     = out_valid && out_ready;
   // Ready depends only on stage state and the downstream side, never on in_valid
   assign in_ready  = !flush && (!held_v || issue);
   assign capture   = in_valid && in_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         held_v  <= 1'b0;
         held_c  <= CTRL_RESET;
         held_pc <= '0;
         held_ra <= '0;
         held_rb <= '0;
      end else if (flush) begin
         held_v <= 1'b0;
      end else if (capture) begin
         held_v  <= 1'b1;
         held_c  <= dec_c;
         held_pc <= in_pc;
         held_ra <= COMMAND[13:11];
         held_rb <= COMMAND[10:8];
      end else if (issue) begin
         held_v <= 1'b0;
      end
   end

   // Flush leaves the counters alone: writes already issued still retire.
   decode_scoreboard #(
      .REG_COUNT    (REG_COUNT),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_scoreboard (
      .clk       (CLK),
      .rst       (RST),
      .rd_a_en   (held_c.rd_a),
      .rd_a_addr (held_ra),
      .rd_b_en   (held_c.rd_b),
      .rd_b_addr (held_rb),
      .wr_en     (held_c.write),
      .wr_addr   (held_rb),
      .issue     (issue),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .hazard    (hazard)
   );

   assign out_pc       = held_pc;
   assign S_ALU        = held_c.s_alu;
   assign signEx       = held_c.sign_ex;
   assign AR_MUX       = held_c.ar_mux;
   assign BR_MUX       = held_c.br_mux;
   assign INPUT_MUX    = held_c.input_mux;
   assign ADR_MUX      = held_c.adr_mux;
   assign write        = held_c.write;
   assign writeEnable  = held_c.write_enable;
   assign PC_load      = held_c.pc_load;
   assign illegal      = held_c.illegal;
   assign writeAddress = held_rb;
   assign ra_addr      = held_ra;
   assign rb_addr      = held_rb;
   assign cond         = held_rb;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. Every accepted command pushes its
// expected decode onto a queue; a negedge monitor pops and compares whenever
// the DUT hands an instruction to execute. Scenario tasks check handshake,
// hazard, flush and illegal-encoding behaviour inline.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   localparam int PC_W = 16;

   typedef struct packed {
      logic [15:0] pc;
      logic [3:0]  s_alu;
      logic        sign_ex;
      logic        ar_mux;
      logic        br_mux;
      logic        input_mux;
      logic        adr_mux;
      logic        wr;
      logic        we;
      logic        pcl;
      logic        ill;
      logic [2:0]  wa;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  cond;
   } exp_t;

   logic            CLK = 1'b0;
   logic            RST;
   logic            in_valid;
   logic            in_ready;
   logic [15:0]     COMMAND;
   logic [PC_W-1:0] in_pc;
   logic            flush;
   logic            wb_valid;
   logic [2:0]      wb_addr;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [3:0]      S_ALU;
   logic            signEx, AR_MUX, BR_MUX, INPUT_MUX, ADR_MUX;
   logic            write, writeEnable, PC_load;
   logic [2:0]      writeAddress, ra_addr, rb_addr, cond;
   logic            illegal;
   logic            stall;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t exp_q[$];
   exp_t act;
   exp_t mon_e;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   decode_stage #(.PC_W(16), .REG_COUNT(8), .MAX_INFLIGHT(3)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .COMMAND      (COMMAND),
      .in_pc        (in_pc),
      .flush        (flush),
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .S_ALU        (S_ALU),
      .signEx       (signEx),
      .AR_MUX       (AR_MUX),
      .BR_MUX       (BR_MUX),
      .INPUT_MUX    (INPUT_MUX),
      .ADR_MUX      (ADR_MUX),
      .write        (write),
      .writeEnable  (writeEnable),
      .PC_load      (PC_load),
      .writeAddress (writeAddress),
      .ra_addr      (ra_addr),
      .rb_addr      (rb_addr),
      .cond         (cond),
      .illegal      (illegal),
      .stall        (stall)
   );

   assign act = {out_pc, S_ALU, signEx, AR_MUX, BR_MUX, INPUT_MUX, ADR_MUX,
                 write, writeEnable, PC_load, illegal, writeAddress, ra_addr,
                 rb_addr, cond};

   // Reference decode, written instruction by instruction from the ISA table
   function automatic exp_t model(input logic [15:0] cmd, input logic [15:0] pc);
      exp_t       e;
      logic [1:0] cls;
      logic [2:0] sub;
      logic [2:0] fld;
      logic [3:0] fn;
      cls = cmd[15:14];
      sub = cmd[13:11];
      fld = cmd[10:8];
      fn  = cmd[7:4];
      e        = '0;
      e.pc     = pc;
      e.wa     = fld;
      e.ra     = sub;
      e.rb     = fld;
      e.cond   = fld;
      e.br_mux = (cls != 2'b10);
      e.s_alu  = 4'b1111;
      if (cls == 2'b11) begin
         e.sign_ex   = 1'b1;
         e.wr        = (fn <= 4'd12);
         e.ar_mux    = (fn <= 4'd6);
         e.adr_mux   = (fn <= 4'd11);
         e.input_mux = (fn == 4'd12);
         e.ill       = (fn == 4'd7);
         if (fn == 4'd5)      e.s_alu = 4'b0001;
         else if (fn == 4'd6) e.s_alu = 4'b1100;
         else                 e.s_alu = fn;
      end else if (cls == 2'b00) begin
         e.wr    = 1'b1;
         e.s_alu = 4'b0000;
      end else if (cls == 2'b01) begin
         e.we    = 1'b1;
         e.s_alu = 4'b0000;
      end else begin
         e.adr_mux = 1'b1;
         if (sub == 3'd0) begin
            e.wr    = 1'b1;
            e.s_alu = 4'b1100;
         end else if (sub == 3'd4 || sub == 3'd7) begin
            e.pcl   = 1'b1;
            e.s_alu = 4'b0000;
            e.ill   = (sub == 3'd7) && (fld > 3'd3);
         end else begin
            e.ill = 1'b1;
         end
      end
      if (e.ill) begin
         e.wr    = 1'b0;
         e.we    = 1'b0;
         e.pcl   = 1'b0;
         e.s_alu = 4'b1111;
      end
      return e;
   endfunction

   // Issue monitor: whatever execute accepts must match the oldest expectation
   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL issue_unexpected: issued pc=%h with nothing expected", out_pc);
         end else begin
            mon_e = exp_q.pop_front();
            if (act !== mon_e) begin
               failures++;
               $display("FAIL issue_fields: actual=%h required=%h", act, mon_e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Offer one command; returns 1 time unit after the capturing edge
   task automatic offer(input logic [15:0] cmd, input logic [15:0] pc);
      bit done = 1'b0;
      in_valid = 1'b1;
      COMMAND  = cmd;
      in_pc    = pc;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge CLK);
         if (in_ready) begin
            exp_q.push_back(model(cmd, pc));
            done = 1'b1;
         end
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL offer_timeout: cmd=%h accepted=0 required=1", cmd);
      end
   endtask

   task automatic retire(input logic [2:0] addr);
      wb_valid = 1'b1;
      wb_addr  = addr;
      @(posedge CLK);
      #1;
      wb_valid = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if ({out_valid, stall, in_ready} !== 3'b001) begin
         failures++;
         $display("FAIL reset_handshake: actual=%b required=001", {out_valid, stall, in_ready});
      end
      checks++;
      if (S_ALU !== 4'b1111) begin
         failures++;
         $display("FAIL reset_s_alu: actual=%b required=1111", S_ALU);
      end
      checks++;
      if ({signEx, AR_MUX, BR_MUX, INPUT_MUX, ADR_MUX, write, writeEnable, PC_load, illegal} !== 9'b0) begin
         failures++;
         $display("FAIL reset_controls: actual=%b required=000000000",
                  {signEx, AR_MUX, BR_MUX, INPUT_MUX, ADR_MUX, write, writeEnable, PC_load, illegal});
      end
      checks++;
      if ({out_pc, writeAddress, ra_addr, rb_addr, cond} !== 28'h0) begin
         failures++;
         $display("FAIL reset_fields: actual=%h required=0", {out_pc, writeAddress, ra_addr, rb_addr, cond});
      end
      tick();
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      offer(16'hC000, 16'h0010);
      @(negedge CLK);
      checks++;
      if ({out_valid, stall} !== 2'b10) begin
         failures++;
         $display("FAIL add_latency: valid,stall=%b required=10", {out_valid, stall});
      end
      checks++;
      if ({S_ALU, write, signEx, AR_MUX, ADR_MUX, BR_MUX} !== 9'b0000_11111) begin
         failures++;
         $display("FAIL add_controls: actual=%b required=000011111",
                  {S_ALU, write, signEx, AR_MUX, ADR_MUX, BR_MUX});
      end
      tick();
      retire(3'd0);
   endtask

   task automatic test_raw_hazard();
      out_ready = 1'b1;
      offer(16'hC200, 16'h0020);   // ADD -> r2
      tick();                      // issues, r2 now pending
      offer(16'hD310, 16'h0022);   // SUB reads r2
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if ({stall, out_valid, in_ready} !== 3'b100) begin
            failures++;
            $display("FAIL raw_stall: stall,valid,ready=%b required=100 cycle=%0d",
                     {stall, out_valid, in_ready}, i);
         end
      end
      retire(3'd2);
      @(negedge CLK);
      checks++;
      if ({out_valid, stall} !== 2'b10) begin
         failures++;
         $display("FAIL raw_release: valid,stall=%b required=10", {out_valid, stall});
      end
      tick();
      retire(3'd3);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      offer(16'h8000, 16'h0030);   // LI r0
      in_valid = 1'b1;             // a competing command must not get in
      COMMAND  = 16'hC000;
      in_pc    = 16'h0032;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if ({out_valid, in_ready, stall} !== 3'b100 || S_ALU !== 4'b1100 ||
             out_pc !== 16'h0030 || writeAddress !== 3'd0) begin
            failures++;
            $display("FAIL hold_stable: valid,ready,stall=%b s_alu=%b pc=%h required=100 1100 0030",
                     {out_valid, in_ready, stall}, S_ALU, out_pc);
         end
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();                      // the held LI issues here
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL single_issue: valid=%b pending=%0d required=0 0", out_valid, exp_q.size());
      end
      tick();
      retire(3'd0);
   endtask

   task automatic test_inflight_limit();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) offer(16'h8500, 16'h0040 + 16'(i));   // LI r5
      offer(16'h8500, 16'h0050);   // fourth write to r5
      @(negedge CLK);
      checks++;
      if ({stall, out_valid, in_ready} !== 3'b100) begin
         failures++;
         $display("FAIL limit_stall: stall,valid,ready=%b required=100", {stall, out_valid, in_ready});
      end
      retire(3'd5);                // count 3 -> 2, fourth becomes issuable
      wb_valid = 1'b1;             // retire r5 in the same cycle it issues
      wb_addr  = 3'd5;
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL limit_release: valid=%b required=1", out_valid);
      end
      @(posedge CLK);
      #1;
      wb_valid = 1'b0;
      offer(16'h8500, 16'h0060);   // count must still be 2, so this issues
      @(negedge CLK);
      checks++;
      if ({out_valid, stall} !== 2'b10) begin
         failures++;
         $display("FAIL same_cycle_net: valid,stall=%b required=10", {out_valid, stall});
      end
      tick();                      // r5 count now at the limit
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      offer(16'hB900, 16'h0070);   // BCC cond 001, held
      flush    = 1'b1;
      in_valid = 1'b1;
      COMMAND  = 16'hC000;
      in_pc    = 16'h0072;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_in_ready: actual=%b required=0", in_ready);
      end
      @(posedge CLK);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      void'(exp_q.pop_back());     // the flushed BCC never reaches execute
      @(negedge CLK);
      checks++;
      if ({out_valid, stall, in_ready} !== 3'b001) begin
         failures++;
         $display("FAIL flush_clears: valid,stall,ready=%b required=001", {out_valid, stall, in_ready});
      end
      tick();
      out_ready = 1'b1;
      offer(16'h8500, 16'h0074);   // r5 still at the limit after flush
      @(negedge CLK);
      checks++;
      if ({stall, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL flush_keeps_counts: stall,valid=%b required=10", {stall, out_valid});
      end
      retire(3'd5);
      tick();                      // LI issues, r5 back at the limit
      repeat (3) retire(3'd5);
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      offer(16'hC070, 16'h0080);   // ALU func 0111
      @(negedge CLK);
      checks++;
      if ({out_valid, illegal, write, PC_load} !== 4'b1100 || S_ALU !== 4'b1111) begin
         failures++;
         $display("FAIL illegal_alu: valid,ill,wr,pcl=%b s_alu=%b required=1100 1111",
                  {out_valid, illegal, write, PC_load}, S_ALU);
      end
      tick();
      offer(16'hBD00, 16'h0082);   // BCC cond 101
      @(negedge CLK);
      checks++;
      if ({out_valid, illegal, write, PC_load} !== 4'b1100 || S_ALU !== 4'b1111 || cond !== 3'b101) begin
         failures++;
         $display("FAIL illegal_bcc: valid,ill,wr,pcl=%b s_alu=%b cond=%b required=1100 1111 101",
                  {out_valid, illegal, write, PC_load}, S_ALU, cond);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] cmds [7];
      int          start;
      cmds = '{16'h4A00, 16'h0400, 16'hA000, 16'hB900, 16'hC1C0, 16'hC260, 16'hC3D0};
      out_ready = 1'b1;
      start     = cyc;
      for (int i = 0; i < 7; i++) offer(cmds[i], 16'h0090 + 16'(i));
      checks++;
      if (cyc - start != 7) begin
         failures++;
         $display("FAIL b2b_throughput: cycles=%0d required=7", cyc - start);
      end
      tick();
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain: valid=%b pending=%0d required=0 0", out_valid, exp_q.size());
      end
      tick();
      retire(3'd4);
      retire(3'd1);
      retire(3'd2);
   endtask

   initial begin
      RST       = 1'b1;
      in_valid  = 1'b0;
      COMMAND   = 16'h0000;
      in_pc     = '0;
      flush     = 1'b0;
      wb_valid  = 1'b0;
      wb_addr   = 3'd0;
      out_ready = 1'b0;
      test_reset();
      test_add();
      test_raw_hazard();
      test_backpressure();
      test_inflight_limit();
      test_flush();
      test_illegal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
